// File: rtl/libtm_pkg.sv
// libtm: definitions shared by the HySim PCIe mailbox read and write paths.
//   NTHREADIDMSB  MSB index of a core ID (core IDs are NTHREADIDMSB+1 bits)
//   MBX_TOG_BIT   bit of a mailbox word that carries the per-core toggle
//   MBX_DATA_W    payload width of a mailbox word
//   mbx_entry_t   {core_id, data} as captured from a simulated core
//   wr_state_t    mailbox writer FSM states
package libtm;

  localparam int NTHREADIDMSB = 3;
  localparam int MBX_TOG_BIT  = 31;
  localparam int MBX_DATA_W   = 31;

  typedef struct packed {
    logic [NTHREADIDMSB:0]  core_id;
    logic [MBX_DATA_W-1:0]  data;
  } mbx_entry_t;

  typedef enum logic {
    WR_IDLE  = 1'b0,
    WR_WRITE = 1'b1
  } wr_state_t;

endpackage

// File: rtl/pcie_write_mod_fifo.sv
// pcie_wr_fifo: synchronous FIFO of mailbox entries (DEPTH must be a power
// of two, at least 2, so the pointers wrap naturally).
//   clk, rst_n   clock, asynchronous active-low reset (clears pointers/count)
//   push         write push_entry at the tail (caller guarantees not full)
//   push_entry   entry to store
//   pop          drop the head entry (caller guarantees not empty)
//   head         current head entry
//   second       entry behind the head, valid when count >= 2
//   count        number of stored entries
module pcie_wr_fifo
  import libtm::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  mbx_entry_t       push_entry,
  input  logic             pop,
  output mbx_entry_t       head,
  output mbx_entry_t       second,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  mbx_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  assign head   = mem[rd_ptr];
  assign second = mem[rd_ptr + PTR_W'(1)];

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/pcie_write_mod.sv
// pcie_write_mod: host-bound mailbox writer. Words from simulated cores are
// written to RAM slot BASE_ADDR+coreID as {toggle, payload}; the toggle of a
// core flips each time one of its writes is acknowledged, so the host sees a
// new word as a change of bit 31.
//
// Build option: WRITEMOD_FIFO_EN selects a FIFO_DEPTH-entry input FIFO
// (pcie_wr_fifo); without it a single holding register is used and the
// block accepts at most one word every two cycles.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   coreID        source core of FPGA_data
//   FPGA_data     31-bit payload
//   FPGA_valid    payload valid
//   FPGA_ready    block can accept (registered, from fill state only)
//   RAM_addr      write address
//   RAM_wdata     {toggle, payload}
//   RAM_we        write request, held with addr/data stable until RAM_ack
//   RAM_ack       RAM took the write this cycle (ignored while RAM_we=0)
//   id_err        one-cycle pulse: a word with coreID >= NUM_CORES was dropped
//
// Handshakes: the input side transfers on a cycle with FPGA_valid &
// FPGA_ready; the RAM side transfers on a cycle with RAM_we & RAM_ack, and
// while RAM_we is high address and data do not change.
module pcie_write_mod
  import libtm::*;
#(
  parameter int NUM_CORES  = 1,
  parameter int ADDR_W     = 10,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NTHREADIDMSB:0] coreID,
  input  logic [MBX_DATA_W-1:0] FPGA_data,
  input  logic                  FPGA_valid,
  output logic                  FPGA_ready,
  output logic [ADDR_W-1:0]     RAM_addr,
  output logic [31:0]           RAM_wdata,
  output logic                  RAM_we,
  input  logic                  RAM_ack,
  output logic                  id_err
);

`ifdef WRITEMOD_FIFO_EN
  localparam int CAP = FIFO_DEPTH;
`else
  localparam int CAP = 1;
`endif
  localparam int CNT_W = $clog2(CAP + 1);

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("pcie_write_mod: FIFO_DEPTH must be a power of two >= 2");
  end

  wr_state_t         state;
  logic [NUM_CORES-1:0] tog;
  logic [NUM_CORES-1:0] tog_next;

  mbx_entry_t        in_entry;
  mbx_entry_t        load_entry;
  mbx_entry_t        head;
  mbx_entry_t        second;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;

  logic id_ok;
  logic accept;
  logic push;
  logic pop;
  logic more;
  logic load;
  logic tog_bit;

  // The head of the buffer is the word being presented to the RAM; it is
  // only removed when the RAM acknowledges it.
`ifdef WRITEMOD_FIFO_EN
  pcie_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (in_entry),
    .pop        (pop),
    .head       (head),
    .second     (second),
    .count      (count)
  );
`else
  mbx_entry_t hold_entry;
  logic       hold_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_entry <= '0;
    end else begin
      if (pop) begin
        hold_valid <= 1'b0;
      end
      if (push) begin
        hold_valid <= 1'b1;
        hold_entry <= in_entry;
      end
    end
  end

  assign count  = hold_valid;
  assign head   = hold_entry;
  assign second = hold_entry;
`endif

  always_comb begin
    in_entry.core_id = coreID;
    in_entry.data    = FPGA_data;
    id_ok  = (int'(coreID) < NUM_CORES);
    accept = FPGA_valid && FPGA_ready;
    push   = accept && id_ok;
    pop    = RAM_we && RAM_ack;
    more   = (int'(count) >= 2);

    // New RAM contents are loaded when idle and a word arrives, or when the
    // current write is acknowledged and another word is waiting (either
    // already buffered behind the head, or arriving this very cycle).
    load       = ((state == WR_IDLE) && push) || (pop && (more || push));
    load_entry = (pop && more) ? second : in_entry;

    // Toggle flip of the acknowledged write is visible to the next word
    // so back-to-back writes to one core alternate bit 31.
    for (int i = 0; i < NUM_CORES; i++) begin
      tog_next[i] = tog[i] ^ (pop && (int'(head.core_id) == i));
    end
    tog_bit = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (int'(load_entry.core_id) == i) begin
        tog_bit = ~tog_next[i];
      end
    end

    count_next = count + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WR_IDLE;
      tog        <= '0;
      FPGA_ready <= 1'b1;
      RAM_we     <= 1'b0;
      RAM_addr   <= '0;
      RAM_wdata  <= '0;
      id_err     <= 1'b0;
    end else begin
      tog        <= tog_next;
      FPGA_ready <= (int'(count_next) < CAP);
      id_err     <= accept && !id_ok;
      if (load) begin
        RAM_addr  <= ADDR_W'(BASE_ADDR) + ADDR_W'(load_entry.core_id);
        RAM_wdata <= {tog_bit, load_entry.data};
      end
      case (state)
        WR_IDLE: begin
          if (load) begin
            state  <= WR_WRITE;
            RAM_we <= 1'b1;
          end
        end
        WR_WRITE: begin
          if (pop && !load) begin
            state  <= WR_IDLE;
            RAM_we <= 1'b0;
          end
        end
        default: begin
          state  <= WR_IDLE;
          RAM_we <= 1'b0;
        end
      endcase
    end
  end

  // Bit 31 layout is fixed by the mailbox word format.
  if (MBX_TOG_BIT != 31) begin : g_layout_chk
    $error("pcie_write_mod: toggle must be bit 31");
  end

endmodule

// File: doc/pcie_write_mod.md
# pcie_write_mod

Host-bound mailbox writer for HySim PCI-Express control. It is the counterpart of the per-core host-to-FPGA read path. It accepts 31-bit words from FPGA-simulated cores and writes each word into that core's slot in the host-visible RAM. Bit 31 of every written word is a per-core toggle, so the host detects a new word by a change in bit 31. The block sits between the simulated-core I/O interface and the PCIe-shared RAM write port.

## Interface
- `NUM_CORES`, 1: number of mailbox slots and toggle bits.
- `ADDR_W`, 10: RAM address width.
- `BASE_ADDR`, 0: RAM address of core 0's slot. Core n's slot is `BASE_ADDR + n`.
- `FIFO_DEPTH`, 4: input FIFO depth, power of two, used only with `WRITEMOD_FIFO_EN`.

Ports:
- `clk`  in  1  sole clock
- `rst_n`  in  1  asynchronous, active-low reset
- `coreID`  in  NTHREADIDMSB+1  source core of `FPGA_data`
- `FPGA_data`  in  31  payload
- `FPGA_valid`  in  1  payload valid
- `FPGA_ready`  out  1  block can accept
- `RAM_addr`  out  ADDR_W  write address
- `RAM_wdata`  out  32  `{toggle, payload}`
- `RAM_we`  out  1  write request, held until acknowledged
- `RAM_ack`  in  1  RAM accepted the write this cycle
- `id_err`  out  1  one-cycle pulse: an out-of-range `coreID` was dropped

## Operation
- **Accept**: a word is accepted when `FPGA_valid & FPGA_ready`. `coreID` and `FPGA_data` are captured together.
- **Out-of-range ID**: if `coreID >= NUM_CORES`, the word is accepted but discarded. `id_err` pulses the next cycle. No RAM write occurs and no toggle changes.
- **Toggle state**: `tog[NUM_CORES-1:0]` is cleared by reset.
  - A write for core c drives `RAM_wdata = {~tog[c], data}` and `RAM_addr = BASE_ADDR + c`.
  - `tog[c]` flips only in the cycle `RAM_we & RAM_ack`.
  - Consequence: the first word ever written for a core has bit 31 = 1.
- **FSM**: two states, IDLE and WRITE.
  - IDLE → WRITE when the buffer is non-empty. The head entry is presented on the RAM outputs.
  - WRITE holds `RAM_we=1` with address and data stable until `RAM_ack`.
  - On ack, the head is popped. If the buffer is still non-empty, the FSM stays in WRITE and presents the next entry the following cycle; otherwise it returns to IDLE.
- **Same core twice**: consecutive words for the same core use the updated toggle, so bit 31 alternates 1,0,1,…
- **Simultaneous push and pop**: allowed in the same cycle when the buffer is not full. When the buffer is full, `FPGA_ready` is 0 and there is no bypass.
- **Address arithmetic**: `BASE_ADDR + coreID` is computed modulo 2^ADDR_W.

## Timing
- Reset values: `FPGA_ready=1`, `RAM_we=0`, `RAM_addr=0`, `RAM_wdata=0`, `id_err=0`. All toggles are 0, the buffer is empty, the FSM is in IDLE.
- Reset is asynchronous. Asserting it mid-write drops `RAM_we` immediately. A pending word is lost and its toggle is not flipped.
- Latency: a word accepted in cycle N first asserts `RAM_we` in cycle N+1.
- Throughput: with `RAM_ack` held high, one RAM write per cycle.
- `RAM_ack` is ignored when `RAM_we=0`.
- All outputs are registered. `FPGA_ready` depends only on registered fill state.

## Configuration
- `WRITEMOD_FIFO_EN` defined: the buffer is a `FIFO_DEPTH`-entry FIFO of `{coreID, data}`. `FPGA_ready = !full`.
- Macro undefined: the buffer is a single holding register. `FPGA_ready` is 1 only when the register is empty, so sustained throughput is one word per 2 cycles.
- In both cases the RAM-side behaviour is identical.

## Structure
- Shared package `libtm` holds:
  - the mailbox word layout constants (`MBX_TOG_BIT = 31`, `MBX_DATA_W = 31`);
  - the typedef `mbx_entry_t` = `{coreID, data}`, shared with the read path.
- One sub-module, `pcie_wr_fifo`: a parameterised synchronous FIFO of `mbx_entry_t`, instantiated only under `WRITEMOD_FIFO_EN`.

## Test plan
- **First write**: after reset, write core 0 data 0x1234 with ack immediate → one `RAM_we` cycle, addr = BASE_ADDR, wdata = 0x80001234.
- **Same core, three writes**: write core 0 three times (A, B, C) → RAM bit 31 sequence is 1,0,1; data fields are A, B, C in order.
- **Ack stall**: hold `RAM_ack` low 5 cycles → `RAM_we`, addr and data stable all 5 cycles; toggle flips only in the ack cycle.
- **Backpressure** (with `WRITEMOD_FIFO_EN`, depth 4): push 6 words with ack low → `FPGA_ready` drops after 4 accepts; releasing ack drains them in order, one per cycle.
- **Bad ID**: `NUM_CORES=1`, `coreID=1` → `id_err` pulses once, no `RAM_we`, `tog[0]` unchanged.
- **Reset mid-write**: assert `rst_n=0` during WRITE → `RAM_we` falls without a clock edge; after release, the next core 0 write has bit 31 = 1.
